// File: rtl/aia_msi_pkg.sv
// Shared constants and types for the AIA MSI writer: IMSIC file layout, AXI response codes, FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package aia_msi_pkg;

    // Each interrupt file occupies one 4 KiB page; seteipnum_le sits at offset 0 of the page.
    localparam int unsigned FILE_STRIDE   = 4096;
    localparam int unsigned SETEIPNUM_OFF = 0;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_B = 2'd2
    } msi_state_e;

    // 8-bit counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/msi_req_fifo.sv
// Request queue: DEPTH x WIDTH circular buffer with occupancy counter, head visible combinationally.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; push and pop may share a cycle.
module msi_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             ni_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign o_full     = (cnt_q == CNT_W'(DEPTH));
    assign o_empty    = (cnt_q == '0);
    assign do_push    = i_push && !o_full;
    assign do_pop     = i_pop && !o_empty;
    assign o_head_dat = mem_q[rd_ptr_q];

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer and occupancy state, cleared asynchronously.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array needs no reset: entries are only read while the occupancy says they are valid.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_push_dat;
        end
    end

endmodule

// File: rtl/axi_msi_writer.sv
// Turns (hart, file, eiid) MSI requests into 32-bit seteipnum_le AXI writes, one outstanding at a time.
// Latency: 2 cycles from request accept to o_aw_valid when idle; completion on the B handshake.
// Backpressure: o_req_ready follows FIFO not-full; AW and W each hold until their own handshake.
module axi_msi_writer
    import aia_msi_pkg::*;
#(
    parameter int          NR_IMSICS             = 1,
    parameter int          NR_VS_FILES_PER_IMSIC = 0,
    parameter int          NR_SRC                = 30,
    parameter int          FIFO_DEPTH            = 4,
    parameter int          AXI_ADDR_WIDTH        = 64,
    parameter int          AXI_DATA_WIDTH        = 64,
    parameter logic [63:0] IMSIC_BASE            = 64'h2400_0000,
    localparam int         NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
    localparam int         FILE_LEN              = $clog2(NR_INTP_FILES),
    localparam int         HART_LEN              = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1,
    localparam int         NR_SRC_LEN            = $clog2(NR_SRC)
) (
    input  logic                        i_clk,
    input  logic                        ni_rst,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [HART_LEN-1:0]         i_req_hart,
    input  logic [FILE_LEN-1:0]         i_req_file,
    input  logic [NR_SRC_LEN-1:0]       i_req_eiid,
    output logic                        o_aw_valid,
    input  logic                        i_aw_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   o_aw_addr,
    output logic                        o_w_valid,
    input  logic                        i_w_ready,
    output logic [AXI_DATA_WIDTH-1:0]   o_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] o_w_strb,
    input  logic                        i_b_valid,
    output logic                        o_b_ready,
    input  logic [1:0]                  i_b_resp,
    output logic                        o_busy,
    output logic [7:0]                  o_drop_cnt,
    output logic [7:0]                  o_err_cnt
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    localparam logic [AXI_ADDR_WIDTH-1:0] BASE_A        = AXI_ADDR_WIDTH'(IMSIC_BASE);
    localparam logic [AXI_ADDR_WIDTH-1:0] OFFS_A        = AXI_ADDR_WIDTH'(SETEIPNUM_OFF);
    localparam logic [AXI_ADDR_WIDTH-1:0] FILE_STRIDE_A = AXI_ADDR_WIDTH'(FILE_STRIDE);
    localparam logic [AXI_ADDR_WIDTH-1:0] HART_STRIDE_A = AXI_ADDR_WIDTH'(NR_INTP_FILES * FILE_STRIDE);
    // seteipnum_le is a 32-bit register: enable the low four byte lanes only.
    localparam logic [STRB_W-1:0]         STRB_SEIP     = STRB_W'(4'hF);

    typedef struct packed {
        logic [HART_LEN-1:0]   hart;
        logic [FILE_LEN-1:0]   file;
        logic [NR_SRC_LEN-1:0] eiid;
    } msi_req_t;

    msi_state_e        state_q, state_d;
    msi_req_t          entry_q, entry_d;
    logic              aw_valid_q, aw_valid_d;
    logic              w_valid_q, w_valid_d;
    logic              b_ready_q, b_ready_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    msi_req_t fifo_head;
    msi_req_t req_in;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    logic     req_acc;
    logic     req_ok;

    assign req_in  = '{hart: i_req_hart, file: i_req_file, eiid: i_req_eiid};
    assign req_acc = i_req_valid && !fifo_full;
    // EIID 0 is reserved and out-of-range targets have no file to write to; such requests are dropped.
    assign req_ok  = (i_req_eiid != '0)
                  && (32'(i_req_hart) < NR_IMSICS)
                  && (32'(i_req_file) < NR_INTP_FILES);
    assign fifo_push = req_acc && req_ok;

    msi_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(msi_req_t))
    ) u_fifo (
        .i_clk      (i_clk),
        .ni_rst     (ni_rst),
        .i_push     (fifo_push),
        .i_push_dat (req_in),
        .i_pop      (fifo_pop),
        .o_head_dat (fifo_head),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    // Dropped-request counter, saturating.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (req_acc && !req_ok) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end
    end

    // Transaction sequencer: latch head, drive AW/W until each handshakes, then collect B.
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        strb_d     = strb_q;
        err_cnt_d  = err_cnt_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    entry_d    = fifo_head;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    strb_d     = STRB_SEIP;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (aw_valid_q && i_aw_ready) begin
                    aw_valid_d = 1'b0;
                end
                if (w_valid_q && i_w_ready) begin
                    w_valid_d = 1'b0;
                end
                if (!aw_valid_d && !w_valid_d) begin
                    b_ready_d = 1'b1;
                    state_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_b_valid) begin
                    b_ready_d = 1'b0;
                    state_d   = IDLE;
                    // Error responses are counted only; the write is not retried.
                    if (i_b_resp != AXI_RESP_OKAY) begin
                        err_cnt_d = sat_inc8(err_cnt_q);
                    end
                end
            end
            default: begin
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                b_ready_d  = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // Sequencer state, registered handshake outputs and counters; reset abandons any transaction.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q    <= IDLE;
            entry_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            strb_q     <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            strb_q     <= strb_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Address and data come from the latched entry so they hold steady through the handshakes.
    assign o_aw_addr   = BASE_A + OFFS_A
                       + AXI_ADDR_WIDTH'(entry_q.hart) * HART_STRIDE_A
                       + AXI_ADDR_WIDTH'(entry_q.file) * FILE_STRIDE_A;
    assign o_w_data    = AXI_DATA_WIDTH'(entry_q.eiid);
    assign o_w_strb    = strb_q;
    assign o_aw_valid  = aw_valid_q;
    assign o_w_valid   = w_valid_q;
    assign o_b_ready   = b_ready_q;
    assign o_req_ready = !fifo_full;
    assign o_busy      = !fifo_empty || (state_q != IDLE);
    assign o_drop_cnt  = drop_cnt_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axi_msi_writer.sv
// Bench for axi_msi_writer: default-parameter instance driven by a responsive AXI slave model,
// plus a 4-hart / 3-file instance for address layout and file-range drops.
// Writes are checked against a scoreboard queue filled when requests are accepted.
module tb_axi_msi_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance 0: defaults (1 hart, 2 files, depth 4)
    logic        req_valid, req_ready;
    logic [0:0]  req_hart, req_file;
    logic [4:0]  req_eiid;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready, busy;
    logic [63:0] aw_addr, w_data;
    logic [7:0]  w_strb, drop_cnt, err_cnt;
    logic [1:0]  b_resp;

    // Instance 1: 4 harts, 3 files per hart
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_hart, req1_file;
    logic [4:0]  req1_eiid;
    logic        aw1_valid, aw1_ready, w1_valid, w1_ready, b1_valid, b1_ready, busy1;
    logic [63:0] aw1_addr, w1_data;
    logic [7:0]  w1_strb, drop1_cnt, err1_cnt;
    logic [1:0]  b1_resp;

    axi_msi_writer #(
        .NR_IMSICS(1), .NR_VS_FILES_PER_IMSIC(0), .NR_SRC(30), .FIFO_DEPTH(4),
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .IMSIC_BASE(64'h2400_0000)
    ) dut (
        .i_clk(clk), .ni_rst(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_hart(req_hart), .i_req_file(req_file), .i_req_eiid(req_eiid),
        .o_aw_valid(aw_valid), .i_aw_ready(aw_ready), .o_aw_addr(aw_addr),
        .o_w_valid(w_valid), .i_w_ready(w_ready), .o_w_data(w_data), .o_w_strb(w_strb),
        .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_resp(b_resp),
        .o_busy(busy), .o_drop_cnt(drop_cnt), .o_err_cnt(err_cnt)
    );

    axi_msi_writer #(
        .NR_IMSICS(4), .NR_VS_FILES_PER_IMSIC(1), .NR_SRC(30), .FIFO_DEPTH(4),
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .IMSIC_BASE(64'h2400_0000)
    ) dut1 (
        .i_clk(clk), .ni_rst(rst_n),
        .i_req_valid(req1_valid), .o_req_ready(req1_ready),
        .i_req_hart(req1_hart), .i_req_file(req1_file), .i_req_eiid(req1_eiid),
        .o_aw_valid(aw1_valid), .i_aw_ready(aw1_ready), .o_aw_addr(aw1_addr),
        .o_w_valid(w1_valid), .i_w_ready(w1_ready), .o_w_data(w1_data), .o_w_strb(w1_strb),
        .i_b_valid(b1_valid), .o_b_ready(b1_ready), .i_b_resp(b1_resp),
        .o_busy(busy1), .o_drop_cnt(drop1_cnt), .o_err_cnt(err1_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [0:0]  hart;
        logic [0:0]  file;
        logic [4:0]  eiid;
        bit          ok;
        logic [63:0] addr;
    } vec_t;
    vec_t vecs[5];

    // Slave model knobs and monitor state
    bit          aw_hold = 1'b0;
    int          w_delay = 0;
    bit          stray_b = 1'b0;
    logic [1:0]  resp_knob = 2'b00;
    int          w_wait = 0;
    int          aw_hs_cnt = 0;
    int          wr_cnt = 0;
    bit          got_aw = 1'b0;
    bit          got_w = 1'b0;
    logic [63:0] cap_addr, cap_data, cap_strb;

    // AXI slave + monitor for instance 0: drive readies at the falling edge, record the
    // handshakes that the next rising edge will complete, score each finished AW+W pair.
    initial begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_resp   = 2'b00;
        forever begin
            @(negedge clk);
            aw_ready = !aw_hold;
            if (w_valid && !aw_valid) w_wait++;
            else w_wait = 0;
            w_ready = (w_delay == 0) || (w_wait >= w_delay);
            b_valid = b_ready || stray_b;
            b_resp  = resp_knob;
            if (rst_n) begin
                if (aw_valid && aw_ready) begin
                    aw_hs_cnt++;
                    got_aw   = 1'b1;
                    cap_addr = aw_addr;
                end
                if (w_valid && w_ready) begin
                    got_w    = 1'b1;
                    cap_data = w_data;
                    cap_strb = 64'(w_strb);
                end
                if (got_aw && got_w) begin
                    got_aw = 1'b0;
                    got_w  = 1'b0;
                    wr_cnt++;
                    if (sb.size() == 0) begin
                        check("unexpected_write", 64'(1), 64'(0));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("wr_addr", cap_addr, e.addr);
                        check("wr_data", cap_data, e.data);
                        check("wr_strb", cap_strb, 64'h0F);
                    end
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [0:0] h, input logic [0:0] f, input logic [4:0] e,
                        input bit ok, input logic [63:0] addr, output bit acc);
        exp_t x;
        @(negedge clk);
        req_hart  = h;
        req_file  = f;
        req_eiid  = e;
        req_valid = 1'b1;
        acc = req_ready;
        if (acc && ok) begin
            x.addr = addr;
            x.data = 64'(e);
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        check({name, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_aw_valid"}, 64'(aw_valid), 64'(0));
        check({tag, "_w_valid"},  64'(w_valid),  64'(0));
        check({tag, "_b_ready"},  64'(b_ready),  64'(0));
        check({tag, "_busy"},     64'(busy),     64'(0));
        check({tag, "_req_ready"},64'(req_ready),64'(1));
        check({tag, "_aw_addr"},  aw_addr,       64'h2400_0000);
        check({tag, "_w_data"},   w_data,        64'(0));
        check({tag, "_w_strb"},   64'(w_strb),   64'(0));
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(0));
        check({tag, "_err_cnt"},  64'(err_cnt),  64'(0));
    endtask

    initial begin
        bit acc;
        int n;
        int wr0;
        int aw0;

        rst_n = 1'b0;
        req_valid = 1'b0; req_hart = '0; req_file = '0; req_eiid = '0;
        req1_valid = 1'b0; req1_hart = '0; req1_file = '0; req1_eiid = '0;
        aw1_ready = 1'b1; w1_ready = 1'b1; b1_valid = 1'b1; b1_resp = 2'b00;

        vecs[0] = '{hart: 1'b0, file: 1'b0, eiid: 5'd1,  ok: 1'b1, addr: 64'h2400_0000};
        vecs[1] = '{hart: 1'b0, file: 1'b1, eiid: 5'd31, ok: 1'b1, addr: 64'h2400_1000};
        vecs[2] = '{hart: 1'b0, file: 1'b1, eiid: 5'd0,  ok: 1'b0, addr: 64'h0};
        vecs[3] = '{hart: 1'b1, file: 1'b0, eiid: 5'd3,  ok: 1'b0, addr: 64'h0};
        vecs[4] = '{hart: 1'b0, file: 1'b0, eiid: 5'd17, ok: 1'b1, addr: 64'h2400_0000};

        #22;
        reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_outputs("post_rst");

        // Single request, readies high: 2-cycle accept-to-AW latency, idle after B.
        send(1'b0, 1'b1, 5'd5, 1'b1, 64'h2400_1000, acc);
        check("t1_acc", 64'(acc), 64'(1));
        @(negedge clk);
        check("t1_aw_cycle1", 64'(aw_valid), 64'(0));
        @(negedge clk);
        check("t1_aw_cycle2", 64'(aw_valid), 64'(1));
        check("t1_busy_mid", 64'(busy), 64'(1));
        wait_idle("t1");
        check("t1_wr_cnt", 64'(wr_cnt), 64'(1));

        // Table of single requests, including both drop causes.
        begin
            int exp_wr;
            int exp_drop;
            exp_wr = wr_cnt;
            exp_drop = 0;
            for (int i = 0; i < 5; i++) begin
                send(vecs[i].hart, vecs[i].file, vecs[i].eiid, vecs[i].ok, vecs[i].addr, acc);
                check("vec_acc", 64'(acc), 64'(1));
                wait_idle("vec");
                repeat (2) @(negedge clk);
                if (vecs[i].ok) exp_wr++;
                else exp_drop++;
                check("vec_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
                check("vec_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            end
        end

        // B valid outside WAIT_B is ignored.
        stray_b = 1'b1;
        resp_knob = 2'b10;
        repeat (4) @(negedge clk);
        check("stray_b_err", 64'(err_cnt), 64'(0));
        check("stray_b_busy", 64'(busy), 64'(0));
        stray_b = 1'b0;
        resp_knob = 2'b00;

        // Five back-to-back requests with AW stalled: 1 latched + 4 queued, then full.
        wr0 = wr_cnt;
        aw_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send(1'b0, 1'(k % 2), 5'(k + 1), 1'b1, (k % 2 == 1) ? 64'h2400_1000 : 64'h2400_0000, acc);
            check("b2b_acc", 64'(acc), 64'(1));
        end
        @(negedge clk);
        check("b2b_full_ready", 64'(req_ready), 64'(0));
        check("b2b_aw_valid", 64'(aw_valid), 64'(1));
        send(1'b0, 1'b0, 5'd9, 1'b1, 64'h2400_0000, acc);
        check("b2b_acc6", 64'(acc), 64'(0));
        aw_hold = 1'b0;
        wait_idle("b2b");
        check("b2b_wr_cnt", 64'(wr_cnt - wr0), 64'(5));
        check("b2b_sb_empty", 64'(sb.size()), 64'(0));

        // W ready delayed 3 cycles after the AW handshake.
        w_delay = 3;
        send(1'b0, 1'b1, 5'd7, 1'b1, 64'h2400_1000, acc);
        n = 0;
        do begin @(negedge clk); n++; end while (!aw_valid && n < 50);
        check("wd_aw_seen", 64'(aw_valid), 64'(1));
        n = 0;
        do begin @(negedge clk); n++; end while (aw_valid && n < 50);
        for (int c = 0; c < 3; c++) begin
            check("wd_aw_low", 64'(aw_valid), 64'(0));
            check("wd_w_held", 64'(w_valid), 64'(1));
            check("wd_w_data", w_data, 64'd7);
            check("wd_no_wait_b", 64'(b_ready), 64'(0));
            if (c < 2) @(negedge clk);
        end
        @(negedge clk);
        check("wd_wait_b", 64'(b_ready), 64'(1));
        w_delay = 0;
        wait_idle("wd");

        // Error response counted, next request still proceeds.
        resp_knob = 2'b10;
        send(1'b0, 1'b0, 5'd9, 1'b1, 64'h2400_0000, acc);
        wait_idle("err1");
        check("err_cnt_1", 64'(err_cnt), 64'(1));
        resp_knob = 2'b00;
        wr0 = wr_cnt;
        send(1'b0, 1'b1, 5'd10, 1'b1, 64'h2400_1000, acc);
        wait_idle("err2");
        check("err_cnt_hold", 64'(err_cnt), 64'(1));
        check("err_next_wr", 64'(wr_cnt - wr0), 64'(1));

        // 300 dropped requests saturate the drop counter with no AXI traffic.
        wr0 = wr_cnt;
        aw0 = aw_hs_cnt;
        for (int k = 0; k < 300; k++) begin
            send(1'b0, 1'(k % 2), 5'd0, 1'b0, 64'h0, acc);
        end
        repeat (4) @(negedge clk);
        check("drop_sat", 64'(drop_cnt), 64'd255);
        check("drop_no_aw", 64'(aw_hs_cnt - aw0), 64'(0));
        check("drop_no_wr", 64'(wr_cnt - wr0), 64'(0));

        // Reset pulsed during SEND abandons the transaction and the queue.
        aw_hold = 1'b1;
        send(1'b0, 1'b0, 5'd11, 1'b1, 64'h2400_0000, acc);
        send(1'b0, 1'b1, 5'd12, 1'b1, 64'h2400_1000, acc);
        n = 0;
        do begin @(negedge clk); n++; end while (!aw_valid && n < 50);
        check("mid_rst_in_send", 64'(aw_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs("mid_rst");
        sb.delete();
        got_aw = 1'b0;
        got_w = 1'b0;
        aw_hold = 1'b0;
        wr0 = wr_cnt;
        aw0 = aw_hs_cnt;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_no_aw", 64'(aw_hs_cnt - aw0), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));
        send(1'b0, 1'b1, 5'd13, 1'b1, 64'h2400_1000, acc);
        wait_idle("post_rst");
        check("post_rst_wr", 64'(wr_cnt - wr0), 64'(1));

        // 4 harts x 3 files: hart 3 file 2 address, then an out-of-range file.
        @(negedge clk);
        req1_hart = 2'd3; req1_file = 2'd2; req1_eiid = 5'd29; req1_valid = 1'b1;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!aw1_valid && n < 50);
        check("h4_aw_valid", 64'(aw1_valid), 64'(1));
        check("h4_aw_addr", aw1_addr, 64'h2400_B000);
        check("h4_w_data", w1_data, 64'd29);
        check("h4_w_strb", 64'(w1_strb), 64'h0F);
        @(negedge clk);
        req1_hart = 2'd1; req1_file = 2'd3; req1_eiid = 5'd4; req1_valid = 1'b1;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("h4_file_drop", 64'(drop1_cnt), 64'(1));
        check("h4_idle", 64'(busy1), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_msi_writer.md
AXI_MSI_WRITER -- requirements
Module: axi_msi_writer

Interface
REQ-001 Parameters SHALL be: NR_IMSICS, default 1, number of IMSIC harts addressed; NR_VS_FILES_PER_IMSIC, default 0, guest files per IMSIC; NR_SRC, default 30, EIID range; FIFO_DEPTH, default 4, power of two ≥2; AXI_ADDR_WIDTH, default 64; AXI_DATA_WIDTH, default 64; IMSIC_BASE, default 64'h2400_0000, address of hart 0 file 0.
REQ-002 Derived values SHALL be: NR_INTP_FILES = 2+NR_VS_FILES_PER_IMSIC; FILE_LEN = $clog2(NR_INTP_FILES); HART_LEN = max(1,$clog2(NR_IMSICS)); NR_SRC_LEN = $clog2(NR_SRC).
REQ-003 The ports SHALL be, clock and reset first: i_clk in 1 clock; ni_rst in 1 asynchronous active-low reset; i_req_valid in 1 MSI request valid; o_req_ready out 1 request accepted; i_req_hart in HART_LEN target IMSIC; i_req_file in FILE_LEN target file (0=M, 1=S, 2+=VS); i_req_eiid in NR_SRC_LEN interrupt identity; o_aw_valid out 1; i_aw_ready in 1; o_aw_addr out AXI_ADDR_WIDTH; o_w_valid out 1; i_w_ready in 1; o_w_data out AXI_DATA_WIDTH; o_w_strb out AXI_DATA_WIDTH/8; i_b_valid in 1; o_b_ready out 1; i_b_resp in 2; o_busy out 1; o_drop_cnt out 8; o_err_cnt out 8.

Function
REQ-004 o_req_ready SHALL be 1 when the FIFO is not full, else 0; a request SHALL be accepted on a cycle with i_req_valid=1 and o_req_ready=1.
REQ-005 An accepted request with i_req_eiid=0, i_req_hart≥NR_IMSICS or i_req_file≥NR_INTP_FILES SHALL NOT be enqueued and SHALL increment o_drop_cnt, saturating at 255.
REQ-006 A valid accepted request SHALL be pushed into a FIFO of FIFO_DEPTH entries; a push and pop in the same cycle SHALL be allowed and leave the occupancy unchanged.
REQ-007 The FSM SHALL have the states IDLE, SEND and WAIT_B.
REQ-008 In IDLE with the FIFO non-empty, the FSM SHALL latch the head entry, pop it, and enter SEND on the next cycle.
REQ-009 Within the same cycle as a push, the FSM SHALL NOT see that push at the head, so the minimum latency from accept to o_aw_valid is 2 cycles.
REQ-010 The write address SHALL be o_aw_addr = IMSIC_BASE + hart*NR_INTP_FILES*4096 + file*4096, computed at AXI_ADDR_WIDTH with wrap-around.
REQ-011 The write data SHALL be o_w_data = the zero-extended EIID, and o_w_strb SHALL be 4'hF in the low bytes with all other bits 0 (seteipnum_le, 32-bit write).
REQ-012 In SEND, o_aw_valid and o_w_valid SHALL both assert.
REQ-013 Each of o_aw_valid and o_w_valid SHALL drop independently after its own handshake and SHALL stay stable until that handshake.
REQ-014 When both handshakes are complete, including both in one cycle, the FSM SHALL enter WAIT_B.
REQ-015 In WAIT_B, o_b_ready SHALL be 1; at i_b_valid=1, the FSM SHALL return to IDLE.
REQ-016 At that response, i_b_resp≠2'b00 SHALL increment o_err_cnt, saturating at 255; there SHALL be no retry.
REQ-017 o_b_ready SHALL be 0 outside WAIT_B, and i_b_valid outside WAIT_B SHALL be ignored.
REQ-018 o_busy SHALL be 1 when the FIFO is non-empty or the FSM is not IDLE.
REQ-019 Requests SHALL be issued strictly in acceptance order, with one outstanding AXI transaction at most.

Reset
REQ-020 On ni_rst=0, asynchronously: FSM←IDLE; FIFO pointers and occupancy←0; the latched entry←0; o_drop_cnt←0; o_err_cnt←0.
REQ-021 During and after reset: o_aw_valid=0, o_w_valid=0, o_b_ready=0, o_busy=0, o_req_ready=1, o_aw_addr=IMSIC_BASE, o_w_data=0, o_w_strb=0.
REQ-022 A reset asserted mid-transaction SHALL abandon the transaction and all queued entries, with no completion reported.

Structure
REQ-023 The file stride (4096), the seteipnum offset (0), the AXI resp encoding OKAY=2'b00, and the FSM state enum SHALL live in a shared package aia_msi_pkg.
REQ-024 The FIFO SHALL be one sub-module, msi_req_fifo (depth/width parameters, push/pop, full/empty); everything else SHALL be in axi_msi_writer.

Verification
REQ-025 Single request hart=0, file=1, eiid=5, with ready held high: aw_addr=0x2400_1000, w_data=5, strb=0x0F, o_aw_valid 2 cycles after accept, o_busy low after the B response.
REQ-026 With NR_IMSICS=4, NR_VS_FILES=1, the request hart=3, file=2, eiid=29: o_aw_addr=0x2400_B000.
REQ-027 Five back-to-back requests, FIFO_DEPTH=4, i_aw_ready=0: o_req_ready drops after the 5th accept (1 latched, 4 queued); releasing ready issues 5 writes in order.
REQ-028 i_w_ready delayed 3 cycles after the AW handshake: o_aw_valid drops after its handshake, o_w_data stays stable, and WAIT_B is entered only after the W handshake.
REQ-029 Requests with eiid=0, then hart=NR_IMSICS: no AXI traffic, o_drop_cnt=2; with 300 such requests, o_drop_cnt=255.
REQ-030 Response with i_b_resp=2'b10: o_err_cnt=1 and the next request proceeds; ni_rst pulsed during SEND: all outputs take their reset values immediately and the queue is empty.
